// File: rtl/rri_control_pkg.sv
// rri_control_pkg: shared constants and helpers for the rri_control AXI4-Lite register file.
//  - AXI response codes
//  - register index map
//  - apply_wstrb(): byte-lane merge of a write into an existing word
package rri_control_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_BYTES  = REG_W / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int unsigned REG_CTRL = 0;
  localparam int unsigned REG_CFG0 = 1;
  localparam int unsigned REG_CFG1 = 2;
  localparam int unsigned REG_STAT = 3;

  // Replace each byte of old_word whose strobe bit is set with the matching byte of data.
  function automatic logic [REG_W-1:0] apply_wstrb(input logic [REG_W-1:0]     old_word,
                                                   input logic [REG_W-1:0]     data,
                                                   input logic [REG_BYTES-1:0] strb);
    logic [REG_W-1:0] res;
    res = old_word;
    for (int b = 0; b < int'(REG_BYTES); b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = data[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rri_control_s_axi_regs.sv
// rri_control_s_axi_regs: AXI4-Lite slave holding NUM_REGS x 32-bit control registers.
//  ACLK/ARESETN        : clock, asynchronous active-low reset
//  S_AXI_AW*/W*/B*     : write channels; AW and W buffered independently, one outstanding write
//  S_AXI_AR*/R*        : read channel; one outstanding read
//  reg_q               : flattened register contents, reg n at [32n+31:32n]
//  reg_wr_pulse        : one-cycle pulse per register when a write commits to it
module rri_control_s_axi_regs
  import rri_control_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  localparam int unsigned NUM_REGS = 1 << (C_S_AXI_ADDR_WIDTH - 2)
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                  reg_wr_pulse
);

  localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW    = C_S_AXI_DATA_WIDTH / 8;

  // Write-side buffers and response
  logic             aw_full_q, aw_full_d;
  logic [IDX_W-1:0] aw_idx_q,  aw_idx_d;
  logic             w_full_q,  w_full_d;
  logic [DW-1:0]    w_data_q,  w_data_d;
  logic [SW-1:0]    w_strb_q,  w_strb_d;
  logic             bvalid_q,  bvalid_d;
  logic             awready_q, awready_d;
  logic             wready_q,  wready_d;

  // Read side
  logic             arready_q, arready_d;
  logic             rvalid_q,  rvalid_d;
  logic [DW-1:0]    rdata_q,   rdata_d;

  // Register storage
  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic aw_hs_c, w_hs_c, ar_hs_c;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_c;
  assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Next-state logic for both channels and the register array
  always_comb begin
    aw_full_d  = aw_full_q;
    aw_idx_d   = aw_idx_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;

    aw_hs_c = S_AXI_AWVALID && awready_q;
    w_hs_c  = S_AXI_WVALID  && wready_q;
    ar_hs_c = S_AXI_ARVALID && arready_q;

    if (aw_hs_c) begin
      aw_full_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs_c) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Commit once both halves are present (buffered or arriving this edge).
    // Buffers are always empty while BVALID is high, so this cannot collide with a pending response.
    if (aw_full_d && w_full_d) begin
      regs_d[aw_idx_d]     = apply_wstrb(regs_q[aw_idx_d], w_data_d, w_strb_d);
      wr_pulse_d[aw_idx_d] = 1'b1;
      bvalid_d             = 1'b1;
      aw_full_d            = 1'b0;
      w_full_d             = 1'b0;
    end

    awready_d = !aw_full_d && !bvalid_d;
    wready_d  = !w_full_d  && !bvalid_d;

    if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    // Reads sample regs_q, so a same-edge write commit is not visible to this read.
    if (ar_hs_c) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]];
    end
    arready_d = !rvalid_d;
  end

  // State registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Flatten register array onto the datapath bus
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      reg_q[DW*i +: DW] = regs_q[i];
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BRESP   = AXI_RESP_OKAY;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = AXI_RESP_OKAY;
  assign S_AXI_RVALID  = rvalid_q;
  assign reg_wr_pulse  = wr_pulse_q;

endmodule

// File: tb/tb_rri_control_s_axi_regs.sv
// Testbench for rri_control_s_axi_regs: randomized AXI4-Lite traffic checked against a
// simple array model of the four registers.
module tb_rri_control_s_axi_regs;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic [3:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [3:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] reg_q;
  logic [3:0]   reg_wr_pulse;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [4];

  always #5 ACLK = ~ACLK;

  rri_control_s_axi_regs dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .reg_q         (reg_q),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  // Reference byte merge: expand strobes into a bit mask.
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // AW and W in the same cycle; reports whether BVALID followed the handshake and the pulse seen then.
  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    output logic ok, output logic [3:0] pulse);
    int n;
    n = 0;
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 20) begin
      tick();
      n++;
    end
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    ok    = (n < 20) && S_AXI_BVALID && (S_AXI_BRESP == 2'b00);
    pulse = reg_wr_pulse;
    tick();
  endtask

  task automatic rd(input logic [3:0] addr, output logic ok, output logic [31:0] data);
    int n;
    n = 0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && n < 20) begin
      tick();
      n++;
    end
    tick();
    S_AXI_ARVALID = 1'b0;
    ok   = (n < 20) && S_AXI_RVALID && (S_AXI_RRESP == 2'b00);
    data = S_AXI_RDATA;
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0) begin
      errors++; $display("FAIL reset_valids: bvalid=%b rvalid=%b want 0 0", S_AXI_BVALID, S_AXI_RVALID);
    end
    checks++;
    if (reg_q !== '0 || reg_wr_pulse !== 4'b0 || S_AXI_RDATA !== 32'h0) begin
      errors++; $display("FAIL reset_state: reg_q=%h pulse=%b rdata=%h want 0", reg_q, reg_wr_pulse, S_AXI_RDATA);
    end
    checks++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1) begin
      errors++; $display("FAIL reset_ready: aw=%b w=%b ar=%b want 1 1 1", S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY);
    end
  endtask

  task automatic test_basic_writes();
    logic ok;
    logic [3:0] p;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      wr({2'(i), 2'b00}, 32'(i + 1), 4'hF, ok, p);
      model[i] = 32'(i + 1);
      checks++;
      if (ok !== 1'b1 || p !== 4'(1 << i)) begin
        errors++; $display("FAIL basic_wr%0d: bvalid_ok=%b pulse=%b want 1 %b", i, ok, p, 4'(1 << i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      rd({2'(i), 2'b00}, ok, d);
      checks++;
      if (ok !== 1'b1 || d !== model[i]) begin
        errors++; $display("FAIL basic_rd%0d: ok=%b got %h want %h", i, ok, d, model[i]);
      end
    end
  endtask

  task automatic test_split();
    int a;
    logic [31:0] d;
    for (int ord = 0; ord < 2; ord++) begin
      a = int'($urandom_range(0, 3));
      d = $urandom;
      S_AXI_AWADDR = {2'(a), 2'(ord)};
      S_AXI_WDATA  = d;
      S_AXI_WSTRB  = 4'hF;
      if (ord == 0) S_AXI_AWVALID = 1'b1; else S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        checks++;
        if ((ord == 0 ? S_AXI_AWREADY : S_AXI_WREADY) !== 1'b0) begin
          errors++; $display("FAIL split%0d_busy_ready t+%0d: got 1 want 0", ord, k);
        end
        checks++;
        if ((ord == 0 ? S_AXI_WREADY : S_AXI_AWREADY) !== 1'b1) begin
          errors++; $display("FAIL split%0d_other_ready t+%0d: got 0 want 1", ord, k);
        end
        checks++;
        if (S_AXI_BVALID !== 1'b0 || reg_wr_pulse !== 4'b0) begin
          errors++; $display("FAIL split%0d_early t+%0d: bvalid=%b pulse=%b want 0", ord, k, S_AXI_BVALID, reg_wr_pulse);
        end
        if (k < 3) tick();
      end
      if (ord == 0) S_AXI_WVALID = 1'b1; else S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      model[a] = d;
      checks++;
      if (S_AXI_BVALID !== 1'b1 || reg_wr_pulse !== 4'(1 << a) || S_AXI_AWREADY !== 1'b0) begin
        errors++; $display("FAIL split%0d_commit: bvalid=%b pulse=%b awready=%b want 1 %b 0",
                           ord, S_AXI_BVALID, reg_wr_pulse, S_AXI_AWREADY, 4'(1 << a));
      end
      checks++;
      if (reg_q[32*a +: 32] !== d) begin
        errors++; $display("FAIL split%0d_data: got %h want %h", ord, reg_q[32*a +: 32], d);
      end
      tick();
      checks++;
      if (S_AXI_BVALID !== 1'b0 || reg_wr_pulse !== 4'b0) begin
        errors++; $display("FAIL split%0d_after: bvalid=%b pulse=%b want 0", ord, S_AXI_BVALID, reg_wr_pulse);
      end
    end
  endtask

  task automatic test_wstrb();
    logic ok;
    logic [3:0] p;
    logic [31:0] d;
    wr(4'h0, 32'hAABBCCDD, 4'hF, ok, p);
    wr(4'h0, 32'h11223344, 4'b0101, ok, p);
    model[0] = 32'hAA22CC44;
    rd(4'h0, ok, d);
    checks++;
    if (d !== 32'hAA22CC44) begin
      errors++; $display("FAIL wstrb_0101: got %h want aa22cc44", d);
    end
    wr(4'h0, 32'hFFFFFFFF, 4'h0, ok, p);
    checks++;
    if (ok !== 1'b1 || p !== 4'b0001 || reg_q[31:0] !== 32'hAA22CC44) begin
      errors++; $display("FAIL wstrb_zero: ok=%b pulse=%b reg0=%h want 1 0001 aa22cc44", ok, p, reg_q[31:0]);
    end
  endtask

  task automatic test_random();
    logic ok;
    logic [3:0] p, s;
    logic [31:0] d, got;
    int a, r;
    for (int it = 0; it < 24; it++) begin
      a = int'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      wr({2'(a), 2'($urandom)}, d, s, ok, p);
      model[a] = merge(model[a], d, s);
      checks++;
      if (ok !== 1'b1 || p !== 4'(1 << a)) begin
        errors++; $display("FAIL rand_wr%0d: ok=%b pulse=%b want 1 %b", it, ok, p, 4'(1 << a));
      end
      checks++;
      if (reg_q !== {model[3], model[2], model[1], model[0]}) begin
        errors++; $display("FAIL rand_regq%0d: got %h want %h", it, reg_q, {model[3], model[2], model[1], model[0]});
      end
      r = int'($urandom_range(0, 3));
      rd({2'(r), 2'($urandom)}, ok, got);
      checks++;
      if (ok !== 1'b1 || got !== model[r]) begin
        errors++; $display("FAIL rand_rd%0d: ok=%b got %h want %h", it, ok, got, model[r]);
      end
    end
  endtask

  task automatic test_bready_hold();
    logic [31:0] d1, d2;
    d1 = $urandom;
    d2 = $urandom;
    S_AXI_BREADY  = 1'b0;
    S_AXI_AWADDR  = 4'h4;
    S_AXI_WDATA   = d1;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    tick();
    model[1] = d1;
    S_AXI_AWADDR = 4'hC;
    S_AXI_WDATA  = d2;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) begin
        errors++; $display("FAIL bhold_c%0d: bvalid=%b awready=%b wready=%b want 1 0 0",
                           k, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
      end
      tick();
    end
    checks++;
    if (reg_q[63:32] !== d1 || reg_q[127:96] !== model[3]) begin
      errors++; $display("FAIL bhold_regs: r1=%h r3=%h want %h %h", reg_q[63:32], reg_q[127:96], d1, model[3]);
    end
    S_AXI_BREADY = 1'b1;
    tick();
    checks++;
    if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1) begin
      errors++; $display("FAIL bhold_release: bvalid=%b awready=%b wready=%b want 0 1 1",
                         S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
    end
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    model[3] = d2;
    checks++;
    if (S_AXI_BVALID !== 1'b1 || reg_q[127:96] !== d2) begin
      errors++; $display("FAIL bhold_second: bvalid=%b r3=%h want 1 %h", S_AXI_BVALID, reg_q[127:96], d2);
    end
    tick();
  endtask

  task automatic test_read_hold();
    logic [31:0] oldv, newv;
    oldv = model[2];
    newv = ~oldv;
    S_AXI_RREADY  = 1'b0;
    S_AXI_ARADDR  = 4'h8;
    S_AXI_ARVALID = 1'b1;
    S_AXI_AWADDR  = 4'h8;
    S_AXI_WDATA   = newv;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARADDR  = 4'h0;
    model[2] = newv;
    checks++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== oldv || S_AXI_BVALID !== 1'b1 || reg_q[95:64] !== newv) begin
      errors++; $display("FAIL rw_same_edge: rvalid=%b rdata=%h bvalid=%b r2=%h want 1 %h 1 %h",
                         S_AXI_RVALID, S_AXI_RDATA, S_AXI_BVALID, reg_q[95:64], oldv, newv);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== oldv || S_AXI_ARREADY !== 1'b0) begin
        errors++; $display("FAIL rhold_c%0d: rvalid=%b rdata=%h arready=%b want 1 %h 0",
                           k, S_AXI_RVALID, S_AXI_RDATA, S_AXI_ARREADY, oldv);
      end
    end
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b1;
    tick();
    checks++;
    if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
      errors++; $display("FAIL rhold_release: rvalid=%b arready=%b want 0 1", S_AXI_RVALID, S_AXI_ARREADY);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    logic [31:0] d, got;
    d = $urandom;
    S_AXI_AWADDR  = 4'h4;
    S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    S_AXI_ARADDR  = 4'h4;
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    checks++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0) begin
      errors++; $display("FAIL rst_setup: rvalid=%b awready=%b want 1 0", S_AXI_RVALID, S_AXI_AWREADY);
    end
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if (S_AXI_RVALID !== 1'b0 || S_AXI_BVALID !== 1'b0 || reg_q !== '0 || S_AXI_RDATA !== 32'h0) begin
      errors++; $display("FAIL rst_async: rvalid=%b bvalid=%b reg_q=%h rdata=%h want all 0",
                         S_AXI_RVALID, S_AXI_BVALID, reg_q, S_AXI_RDATA);
    end
    #3 ARESETN = 1'b1;
    S_AXI_RREADY = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    // A lone W must not pair with the AW that was buffered before reset.
    S_AXI_WDATA  = d;
    S_AXI_WSTRB  = 4'hF;
    S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    tick();
    checks++;
    if (S_AXI_BVALID !== 1'b0 || reg_q !== '0) begin
      errors++; $display("FAIL rst_stale_aw: bvalid=%b reg_q=%h want 0 0", S_AXI_BVALID, reg_q);
    end
    S_AXI_AWADDR  = 4'h0;
    S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    model[0] = d;
    checks++;
    if (S_AXI_BVALID !== 1'b1 || reg_q[31:0] !== d) begin
      errors++; $display("FAIL rst_complete: bvalid=%b r0=%h want 1 %h", S_AXI_BVALID, reg_q[31:0], d);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      rd({2'(i), 2'b00}, ok, got);
      checks++;
      if (ok !== 1'b1 || got !== model[i]) begin
        errors++; $display("FAIL rst_rd%0d: ok=%b got %h want %h", i, ok, got, model[i]);
      end
    end
  endtask

  initial begin
    ARESETN       = 1'b0;
    S_AXI_AWADDR  = '0;
    S_AXI_AWPROT  = 3'b0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b1;
    S_AXI_ARADDR  = '0;
    S_AXI_ARPROT  = 3'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    #23 ARESETN = 1'b1;
    tick();

    test_reset();
    test_basic_writes();
    test_split();
    test_wstrb();
    test_random();
    test_bready_hold();
    test_read_hold();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
